// File: rtl/cpu7_tlb_arb_pkg.sv
// Shared encodings for the cpu7 TLB lookup-port arbiter: FSM states,
// issuing-source codes and the width of a routed lookup result.
package cpu7_tlb_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [1:0] ST_BUSY_M = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    BUSY_I = ST_BUSY_I,
    BUSY_D = ST_BUSY_D,
    BUSY_M = ST_BUSY_M
  } state_e;

  localparam logic [1:0] SRC_I = 2'd0;
  localparam logic [1:0] SRC_D = 2'd1;
  localparam logic [1:0] SRC_M = 2'd2;

  localparam int EXC_W = 6;

  // Result bundle is {hit, paddr, uncached, exccode}.
  function automatic int res_w(input int pabits);
    return 1 + pabits + 1 + EXC_W;
  endfunction

endpackage

// File: rtl/cpu7_tlb_arb_pick.sv
// Fixed-priority picker (M > D > I) where a starving fetch jumps ahead of D.
module cpu7_tlb_arb_pick
  import cpu7_tlb_arb_pkg::*;
(
  input  logic       i_elig,
  input  logic       d_elig,
  input  logic       m_elig,
  input  logic       starve,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    if (m_elig) begin
      gnt[SRC_M] = 1'b1;
    end else if (d_elig && !starve) begin
      gnt[SRC_D] = 1'b1;
    end else if (i_elig) begin
      gnt[SRC_I] = 1'b1;
    end
  end

endmodule

// File: rtl/cpu7_tlb_arb.sv
// Shares the tlb_wrapper lookup port among fetch, data and maintenance
// requesters with one transaction outstanding and registered result routing.
module cpu7_tlb_arb
  import cpu7_tlb_arb_pkg::*;
#(
  parameter int GRLEN      = 32,
  parameter int PABITS     = 32,
  parameter int OPW        = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [GRLEN-1:0]  i_vaddr,
  input  logic              i_cacop,
  input  logic              i_cancel,
  output logic              i_grant,
  output logic              i_finish,
  output logic              i_hit,
  output logic [PABITS-1:0] i_paddr,
  output logic              i_uncached,
  output logic [5:0]        i_exccode,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [GRLEN-1:0]  d_vaddr,
  output logic              d_grant,
  output logic              d_finish,
  output logic              d_hit,
  output logic [PABITS-1:0] d_paddr,
  output logic              d_uncached,
  output logic [5:0]        d_exccode,
  input  logic              m_req,
  input  logic [OPW-1:0]    m_op,
  input  logic [GRLEN-1:0]  m_vaddr,
  output logic              m_grant,
  output logic              m_finish,
  output logic              t_req,
  output logic [1:0]        t_src,
  output logic [GRLEN-1:0]  t_vaddr,
  output logic              t_wr,
  output logic              t_cacop,
  output logic [OPW-1:0]    t_op,
  input  logic              t_finish,
  input  logic              t_hit,
  input  logic [PABITS-1:0] t_paddr,
  input  logic              t_uncached,
  input  logic [5:0]        t_exccode
);

  localparam int RES_W = res_w(PABITS);
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               drop_q, drop_d;
  logic               i_grant_q, i_grant_d;
  logic               d_grant_q, d_grant_d;
  logic               m_grant_q, m_grant_d;
  logic               i_finish_q, i_finish_d;
  logic               d_finish_q, d_finish_d;
  logic               m_finish_q, m_finish_d;
  logic               t_req_q, t_req_d;
  logic [1:0]         t_src_q, t_src_d;
  logic [GRLEN-1:0]   t_vaddr_q, t_vaddr_d;
  logic               t_wr_q, t_wr_d;
  logic               t_cacop_q, t_cacop_d;
  logic [OPW-1:0]     t_op_q, t_op_d;
  logic [RES_W-1:0]   i_res_q, i_res_d;
  logic [RES_W-1:0]   d_res_q, d_res_d;

  logic [RES_W-1:0]   t_res;
  logic               i_elig;
  logic               starve;
  logic [2:0]         gnt;

  assign t_res  = {t_hit, t_paddr, t_uncached, t_exccode};
  // A fetch being flushed in the same cycle is not worth issuing.
  assign i_elig = i_req && !i_cancel;
  assign starve = i_elig && (starve_cnt_q == CNT_MAX);

  cpu7_tlb_arb_pick u_pick (
    .i_elig (i_elig),
    .d_elig (d_req),
    .m_elig (m_req),
    .starve (starve),
    .gnt    (gnt)
  );

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    i_grant_d    = 1'b0;
    d_grant_d    = 1'b0;
    m_grant_d    = 1'b0;
    i_finish_d   = 1'b0;
    d_finish_d   = 1'b0;
    m_finish_d   = 1'b0;
    t_req_d      = 1'b0;
    t_src_d      = t_src_q;
    t_vaddr_d    = t_vaddr_q;
    t_wr_d       = t_wr_q;
    t_cacop_d    = t_cacop_q;
    t_op_d       = t_op_q;
    i_res_d      = i_res_q;
    d_res_d      = d_res_q;

    case (state_q)
      IDLE: begin
        if (!i_req) begin
          starve_cnt_d = '0;
        end
        if (gnt[SRC_M]) begin
          state_d   = BUSY_M;
          m_grant_d = 1'b1;
          t_req_d   = 1'b1;
          t_src_d   = SRC_M;
          t_vaddr_d = m_vaddr;
          t_wr_d    = 1'b0;
          t_cacop_d = 1'b0;
          t_op_d    = m_op;
        end else if (gnt[SRC_D]) begin
          state_d   = BUSY_D;
          d_grant_d = 1'b1;
          t_req_d   = 1'b1;
          t_src_d   = SRC_D;
          t_vaddr_d = d_vaddr;
          t_wr_d    = d_wr;
          t_cacop_d = 1'b0;
          t_op_d    = '0;
          if (i_req && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (gnt[SRC_I]) begin
          state_d      = BUSY_I;
          i_grant_d    = 1'b1;
          t_req_d      = 1'b1;
          t_src_d      = SRC_I;
          t_vaddr_d    = i_vaddr;
          t_wr_d       = 1'b0;
          t_cacop_d    = i_cacop;
          t_op_d       = '0;
          starve_cnt_d = '0;
        end
      end
      BUSY_I: begin
        if (i_cancel) begin
          drop_d = 1'b1;
        end
        // The wrapper cannot be aborted, so a flushed fetch still waits here.
        if (t_finish) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !i_cancel) begin
            i_finish_d = 1'b1;
            i_res_d    = t_res;
          end
        end
      end
      BUSY_D: begin
        if (t_finish) begin
          state_d    = IDLE;
          d_finish_d = 1'b1;
          d_res_d    = t_res;
        end
      end
      BUSY_M: begin
        if (t_finish) begin
          state_d    = IDLE;
          m_finish_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
      i_grant_q    <= 1'b0;
      d_grant_q    <= 1'b0;
      m_grant_q    <= 1'b0;
      i_finish_q   <= 1'b0;
      d_finish_q   <= 1'b0;
      m_finish_q   <= 1'b0;
      t_req_q      <= 1'b0;
      t_src_q      <= '0;
      t_vaddr_q    <= '0;
      t_wr_q       <= 1'b0;
      t_cacop_q    <= 1'b0;
      t_op_q       <= '0;
      i_res_q      <= '0;
      d_res_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      i_grant_q    <= i_grant_d;
      d_grant_q    <= d_grant_d;
      m_grant_q    <= m_grant_d;
      i_finish_q   <= i_finish_d;
      d_finish_q   <= d_finish_d;
      m_finish_q   <= m_finish_d;
      t_req_q      <= t_req_d;
      t_src_q      <= t_src_d;
      t_vaddr_q    <= t_vaddr_d;
      t_wr_q       <= t_wr_d;
      t_cacop_q    <= t_cacop_d;
      t_op_q       <= t_op_d;
      i_res_q      <= i_res_d;
      d_res_q      <= d_res_d;
    end
  end

  assign i_grant  = i_grant_q;
  assign d_grant  = d_grant_q;
  assign m_grant  = m_grant_q;
  assign i_finish = i_finish_q;
  assign d_finish = d_finish_q;
  assign m_finish = m_finish_q;
  assign t_req    = t_req_q;
  assign t_src    = t_src_q;
  assign t_vaddr  = t_vaddr_q;
  assign t_wr     = t_wr_q;
  assign t_cacop  = t_cacop_q;
  assign t_op     = t_op_q;

  assign {i_hit, i_paddr, i_uncached, i_exccode} = i_res_q;
  assign {d_hit, d_paddr, d_uncached, d_exccode} = d_res_q;

endmodule

// File: tb/tb_cpu7_tlb_arb.sv
// Directed bench for cpu7_tlb_arb with a hand-driven tlb_wrapper response.
module tb_cpu7_tlb_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_cacop, i_cancel;
  logic [31:0] i_vaddr;
  logic        i_grant, i_finish, i_hit, i_uncached;
  logic [31:0] i_paddr;
  logic [5:0]  i_exccode;
  logic        d_req, d_wr;
  logic [31:0] d_vaddr;
  logic        d_grant, d_finish, d_hit, d_uncached;
  logic [31:0] d_paddr;
  logic [5:0]  d_exccode;
  logic        m_req;
  logic [4:0]  m_op;
  logic [31:0] m_vaddr;
  logic        m_grant, m_finish;
  logic        t_req, t_wr, t_cacop;
  logic [1:0]  t_src;
  logic [31:0] t_vaddr;
  logic [4:0]  t_op;
  logic        t_finish, t_hit, t_uncached;
  logic [31:0] t_paddr;
  logic [5:0]  t_exccode;

  int total = 0;
  int bad   = 0;
  int treq_cnt = 0;
  logic [127:0] all_out;

  assign all_out = {i_grant, i_finish, i_hit, i_paddr, i_uncached, i_exccode,
                    d_grant, d_finish, d_hit, d_paddr, d_uncached, d_exccode,
                    m_grant, m_finish,
                    t_req, t_src, t_vaddr, t_wr, t_cacop, t_op};

  cpu7_tlb_arb dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_cacop(i_cacop), .i_cancel(i_cancel),
    .i_grant(i_grant), .i_finish(i_finish), .i_hit(i_hit), .i_paddr(i_paddr),
    .i_uncached(i_uncached), .i_exccode(i_exccode),
    .d_req(d_req), .d_wr(d_wr), .d_vaddr(d_vaddr),
    .d_grant(d_grant), .d_finish(d_finish), .d_hit(d_hit), .d_paddr(d_paddr),
    .d_uncached(d_uncached), .d_exccode(d_exccode),
    .m_req(m_req), .m_op(m_op), .m_vaddr(m_vaddr),
    .m_grant(m_grant), .m_finish(m_finish),
    .t_req(t_req), .t_src(t_src), .t_vaddr(t_vaddr), .t_wr(t_wr),
    .t_cacop(t_cacop), .t_op(t_op),
    .t_finish(t_finish), .t_hit(t_hit), .t_paddr(t_paddr),
    .t_uncached(t_uncached), .t_exccode(t_exccode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (t_req) treq_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wrapper answers lat cycles after the t_req cycle; returns one cycle after t_finish.
  task automatic wrap_finish(input int lat, input logic hit, input logic [31:0] pa,
                             input logic unc, input logic [5:0] exc);
    repeat (lat) tick();
    t_finish = 1'b1; t_hit = hit; t_paddr = pa; t_uncached = unc; t_exccode = exc;
    tick();
    t_finish = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req = 0; i_vaddr = '0; i_cacop = 0; i_cancel = 0;
    d_req = 0; d_wr = 0; d_vaddr = '0;
    m_req = 0; m_op = '0; m_vaddr = '0;
    t_finish = 0; t_hit = 0; t_paddr = '0; t_uncached = 0; t_exccode = '0;
    tick(); tick();
    total++; if (all_out !== 128'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    reset = 1'b0;
    tick();
    total++; if (all_out !== 128'd0) begin bad++; $display("FAIL reset_idle got=%h exp=0", all_out); end
  endtask

  task automatic test_single_i();
    i_req = 1; i_vaddr = 32'h1c00_0000; i_cacop = 0;
    tick();
    total++; if ({i_grant, t_req, t_src} !== 4'b1100) begin bad++; $display("FAIL single_grant got=%b%b%b exp=1100", i_grant, t_req, t_src); end
    total++; if (t_vaddr !== 32'h1c00_0000) begin bad++; $display("FAIL single_vaddr got=%h exp=1c000000", t_vaddr); end
    i_req = 0;
    tick();
    total++; if ({i_grant, t_req} !== 2'b00) begin bad++; $display("FAIL single_pulse got=%b%b exp=00", i_grant, t_req); end
    tick(); tick();
    t_finish = 1; t_hit = 1; t_paddr = 32'h1c00_0000; t_uncached = 0; t_exccode = 6'h0;
    total++; if (i_finish !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", i_finish); end
    tick();
    t_finish = 0;
    total++; if ({i_finish, i_hit, i_exccode} !== 8'b11_000000) begin bad++; $display("FAIL single_finish got=%b%b%h exp=1 1 00", i_finish, i_hit, i_exccode); end
    total++; if (i_paddr !== 32'h1c00_0000) begin bad++; $display("FAIL single_paddr got=%h exp=1c000000", i_paddr); end
    tick();
    total++; if (i_finish !== 1'b0) begin bad++; $display("FAIL single_finish_pulse got=%b exp=0", i_finish); end
  endtask

  task automatic test_priority();
    int start_cnt;
    start_cnt = treq_cnt;
    i_req = 1; i_vaddr = 32'h1c00_0100; i_cacop = 1;
    d_req = 1; d_vaddr = 32'h0000_8000; d_wr = 1;
    m_req = 1; m_op = 5'h0b; m_vaddr = 32'h0000_4000;
    tick();
    total++; if ({m_grant, d_grant, i_grant, t_src} !== 5'b100_10) begin bad++; $display("FAIL prio_m got=%b%b%b src=%0d exp=100 src=2", m_grant, d_grant, i_grant, t_src); end
    total++; if ({t_op, t_vaddr} !== {5'h0b, 32'h0000_4000}) begin bad++; $display("FAIL prio_m_op got=%h/%h exp=0b/00004000", t_op, t_vaddr); end
    m_req = 0;
    wrap_finish(2, 1'b0, 32'h0, 1'b0, 6'h0);
    total++; if ({m_finish, d_finish, i_finish, t_req} !== 4'b1000) begin bad++; $display("FAIL prio_m_finish got=%b%b%b%b exp=1000", m_finish, d_finish, i_finish, t_req); end
    tick();
    total++; if ({d_grant, t_src, t_op, t_wr} !== {1'b1, 2'd1, 5'd0, 1'b1}) begin bad++; $display("FAIL prio_d got=%b src=%0d op=%h wr=%b exp=1 src=1 op=00 wr=1", d_grant, t_src, t_op, t_wr); end
    d_req = 0;
    wrap_finish(1, 1'b1, 32'h0000_8000, 1'b0, 6'h0);
    total++; if ({d_finish, i_finish, m_finish} !== 3'b100) begin bad++; $display("FAIL prio_d_finish got=%b%b%b exp=100", d_finish, i_finish, m_finish); end
    tick();
    total++; if ({i_grant, t_src, t_op, t_cacop} !== {1'b1, 2'd0, 5'd0, 1'b1}) begin bad++; $display("FAIL prio_i got=%b src=%0d op=%h cacop=%b exp=1 src=0 op=00 cacop=1", i_grant, t_src, t_op, t_cacop); end
    i_req = 0; i_cacop = 0;
    wrap_finish(1, 1'b1, 32'h1c00_0100, 1'b0, 6'h0);
    total++; if (treq_cnt - start_cnt !== 3) begin bad++; $display("FAIL prio_treq_count got=%0d exp=3", treq_cnt - start_cnt); end
  endtask

  task automatic test_starve();
    i_req = 1; i_vaddr = 32'h1c00_0200;
    d_req = 1; d_vaddr = 32'h0000_9000; d_wr = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) begin
        total++; if ({d_grant, i_grant, t_src} !== 4'b10_01) begin bad++; $display("FAIL starve_d%0d got=%b%b src=%0d exp=10 src=1", k, d_grant, i_grant, t_src); end
      end else begin
        total++; if ({d_grant, i_grant, t_src} !== 4'b01_00) begin bad++; $display("FAIL starve_i got=%b%b src=%0d exp=01 src=0", d_grant, i_grant, t_src); end
        i_req = 0; d_req = 0;
      end
      wrap_finish(1, 1'b1, 32'h0000_9000, 1'b0, 6'h0);
    end
    total++; if (dut.starve_cnt_q !== 2'd0) begin bad++; $display("FAIL starve_cnt got=%0d exp=0", dut.starve_cnt_q); end
  endtask

  task automatic test_cancel();
    i_req = 1; i_vaddr = 32'h1c00_0040;
    tick();
    total++; if (i_grant !== 1'b1) begin bad++; $display("FAIL cancel_grant got=%b exp=1", i_grant); end
    i_req = 0;
    d_req = 1; d_vaddr = 32'h0000_2000; d_wr = 0;
    tick();
    i_cancel = 1;
    tick();
    i_cancel = 0;
    t_finish = 1; t_hit = 0; t_paddr = 32'h0000_1234; t_uncached = 0; t_exccode = 6'h3;
    tick();
    t_finish = 0;
    total++; if ({i_finish, d_grant} !== 2'b00) begin bad++; $display("FAIL cancel_drop got=%b%b exp=00", i_finish, d_grant); end
    total++; if (i_exccode !== 6'h0) begin bad++; $display("FAIL cancel_exc_held got=%h exp=00", i_exccode); end
    tick();
    total++; if ({d_grant, t_src} !== 3'b1_01) begin bad++; $display("FAIL cancel_pending_d got=%b src=%0d exp=1 src=1", d_grant, t_src); end
    d_req = 0;
    wrap_finish(1, 1'b1, 32'h8000_1234, 1'b1, 6'h0);
    total++; if ({d_finish, d_paddr, d_uncached} !== {1'b1, 32'h8000_1234, 1'b1}) begin bad++; $display("FAIL cancel_d_result got=%b %h %b exp=1 80001234 1", d_finish, d_paddr, d_uncached); end
    i_req = 1;
    tick();
    i_req = 0;
    wrap_finish(1, 1'b1, 32'h1c00_0040, 1'b0, 6'h0);
    total++; if (i_finish !== 1'b1) begin bad++; $display("FAIL cancel_flag_cleared got=%b exp=1", i_finish); end
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_vaddr = 32'h0000_3000;
    tick();
    total++; if (d_grant !== 1'b1) begin bad++; $display("FAIL rmid_grant got=%b exp=1", d_grant); end
    d_req = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    total++; if (all_out !== 128'd0) begin bad++; $display("FAIL rmid_outputs got=%h exp=0", all_out); end
    t_finish = 1; t_hit = 1; t_paddr = 32'h0000_3000; t_uncached = 0; t_exccode = 6'h0;
    tick();
    t_finish = 0;
    total++; if (d_finish !== 1'b0) begin bad++; $display("FAIL rmid_stale1 got=%b exp=0", d_finish); end
    tick();
    total++; if (all_out !== 128'd0) begin bad++; $display("FAIL rmid_stale2 got=%h exp=0", all_out); end
    d_req = 1;
    tick();
    total++; if ({d_grant, t_src, t_vaddr} !== {1'b1, 2'd1, 32'h0000_3000}) begin bad++; $display("FAIL rmid_regrant got=%b src=%0d %h exp=1 src=1 00003000", d_grant, t_src, t_vaddr); end
    d_req = 0;
    wrap_finish(1, 1'b1, 32'h0000_3000, 1'b0, 6'h0);
  endtask

  task automatic test_d_exc();
    d_req = 1; d_vaddr = 32'h0040_0000; d_wr = 0;
    tick();
    total++; if (d_grant !== 1'b1) begin bad++; $display("FAIL dexc_grant got=%b exp=1", d_grant); end
    d_req = 0;
    wrap_finish(2, 1'b0, 32'hdead_0000, 1'b0, 6'h1);
    total++; if ({d_finish, d_hit, d_exccode} !== {1'b1, 1'b0, 6'h1}) begin bad++; $display("FAIL dexc_result got=%b%b %h exp=10 01", d_finish, d_hit, d_exccode); end
    total++; if (d_paddr !== 32'hdead_0000) begin bad++; $display("FAIL dexc_paddr got=%h exp=dead0000", d_paddr); end
    total++; if ({i_finish, m_finish, i_exccode} !== 8'h00) begin bad++; $display("FAIL dexc_routing got=%b%b %h exp=00 00", i_finish, m_finish, i_exccode); end
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_priority();
    test_starve();
    test_cancel();
    test_reset_mid();
    test_d_exc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu7_tlb_arb.md
Name: cpu7_tlb_arb

Overview:
- Shares the single lookup port of tlb_wrapper among three requesters: instruction fetch (I), data access (D) and TLB maintenance ops (M: tlbsrch/tlbrd/tlbwr/invtlb).
- Sits in cpu7 between ifu/lsu/csr-side requesters and tlb_wrapper.
- Enforces one outstanding transaction, fixed priority with anti-starvation for I, and result routing back to the owner.
- Drops results of cancelled fetches.

Parameters:
- GRLEN, 32, virtual address width
- PABITS, 32, physical address width
- OPW, 5, maintenance op code width (LSOC1K_TLB_CODE_BIT)
- STARVE_MAX, 3, consecutive D grants allowed while I waits

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch lookup request (level, held until i_grant)
- i_vaddr  in  GRLEN  fetch vaddr
- i_cacop  in  1  lookup is for cacop
- i_cancel  in  1  fetch flush; drops pending/outstanding I result
- i_grant  out  1  1-cycle accept pulse
- i_finish  out  1  1-cycle result valid
- i_hit  out  1  lookup hit
- i_paddr  out  PABITS  physical address
- i_uncached  out  1  uncached attribute
- i_exccode  out  6  exception code, 0 = none
- d_req  in  1  data lookup request
- d_wr  in  1  store
- d_vaddr  in  GRLEN  data vaddr
- d_grant  out  1  accept pulse
- d_finish  out  1  result valid
- d_hit  out  1  lookup hit
- d_paddr  out  PABITS  physical address
- d_uncached  out  1  uncached attribute
- d_exccode  out  6  exception code
- m_req  in  1  maintenance op request
- m_op  in  OPW  op code
- m_vaddr  in  GRLEN  invtlb operand
- m_grant  out  1  accept pulse
- m_finish  out  1  op complete
- t_req  out  1  1-cycle issue to tlb_wrapper
- t_src  out  2  issuing source: 0=I, 1=D, 2=M
- t_vaddr  out  GRLEN  issued vaddr
- t_wr  out  1  issued store flag
- t_cacop  out  1  issued cacop flag
- t_op  out  OPW  issued op, 0 for lookups
- t_finish  in  1  tlb_wrapper done
- t_hit  in  1  tlb_wrapper hit
- t_paddr  in  PABITS  tlb_wrapper paddr
- t_uncached  in  1  tlb_wrapper uncached
- t_exccode  in  6  tlb_wrapper exccode

Behaviour:
- Reset: all outputs 0; state IDLE; starve_cnt 0; drop flag 0.
- States: IDLE, BUSY_I, BUSY_D, BUSY_M.
- Arbitration in IDLE, requests sampled at cycle N. Priority: M > D > I.
  - Exception: if i_req && starve_cnt==STARVE_MAX, I wins over D (not over M).
- Grant timing: at N+1, the winner's x_grant=1 and t_req=1 with its latched vaddr/flags; state becomes BUSY_x.
- i_req && i_cancel at N: I is not eligible.
- starve_cnt:
  - +1, saturating, on each D grant while i_req=1.
  - Cleared on I grant, or when i_req=0 in IDLE.
- BUSY_x waits for t_finish at cycle M. Results are registered: x_finish plus data at M+1; state returns to IDLE at M+1; next grant earliest M+2. Single-transaction latency is 2 + tlb_wrapper latency.
- t_finish with t_req in the same cycle is impossible: t_req only fires from IDLE.
- t_finish in IDLE (e.g. after reset mid-op) is ignored.
- Result data outputs hold their last value; valid only with x_finish.
- m_finish carries no data; CSR reads results from tlb_wrapper directly.
- i_cancel in BUSY_I, or the same cycle as i_grant, sets the drop flag. At t_finish, i_finish is suppressed and the flag cleared; the arbiter still waits for t_finish (no abort of tlb_wrapper).
- i_cancel in BUSY_D/BUSY_M has no effect.
- Reset mid-operation: immediate return to IDLE; outstanding result lost.

Decomposition:
- Package cpu7_tlb_arb_pkg:
  - state encoding (2-bit localparams);
  - source codes SRC_I=0, SRC_D=1, SRC_M=2;
  - result bundle width (1+PABITS+1+6).
- One sub-module cpu7_tlb_arb_pick: combinational priority picker with starvation override; inputs i/d/m eligibility plus starve flag; output one-hot grant.
- FSM, latches and result routing stay in the top.

Test Plan:
- Single I lookup: i_req, vaddr 0x1c000000, wrapper finishes 3 cycles after t_req with paddr 0x1c000000, hit=1 → i_grant at N+1, t_src=0, i_finish exactly 1 cycle after t_finish, i_exccode=0.
- Simultaneous i_req/d_req/m_req at N → grants in order M, D, I. t_op=m_op only for the M issue. Exactly one t_req per transaction; no overlap.
- D held continuously with I waiting → D granted 3 times; 4th grant goes to I (t_src=0); starve_cnt 0 afterwards.
- i_cancel 1 cycle after i_grant, t_finish with exccode 0x3 → i_finish stays 0. Pending d_req is granted the cycle after the state returns to IDLE.
- reset pulsed while BUSY_D, then stale t_finish → d_finish never asserts; all outputs 0; the next d_req is granted normally.
- D lookup returns exccode 0x1 (PIL), hit=0 → d_finish=1, d_exccode=0x1, d_hit=0, routed only to D (i_finish=0, m_finish=0).
